divider_seq: RTL

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/divider_seq.sv
// Sequential 32-bit integer divider for RV32M DIV/DIVU/REM/REMU.
// Restoring shift-subtract, one quotient bit per cycle, fixed 33-cycle latency.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on accept
// RUN    | 32 shift-subtract steps, counter 0..31
// FINISH | sign/zero correction, result registered, done pulsed
module divider_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_rem_q, is_rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg;
  logic [32:0] rem_sh, diff;
  logic [31:0] q_fix, r_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      dvsr_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      dvsr_q   <= dvsr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    dvsr_d   = dvsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    done_d   = 1'b0;

    a_neg  = ~op[0] & dividend[31];
    b_neg  = ~op[0] & divisor[31];
    // The quotient register doubles as the dividend shift source.
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvsr_q};
    q_fix  = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quo_q + 32'd1) : quo_q);
    r_fix  = r_neg_q ? (~rem_q + 32'd1) : rem_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_rem_d = op[1];
          quo_d    = a_neg ? (~dividend + 32'd1) : dividend;
          dvsr_d   = b_neg ? (~divisor + 32'd1) : divisor;
          rem_d    = '0;
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          dz_d     = (divisor == 32'd0);
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd31) state_d = FINISH;
        else                cnt_d   = cnt_q + 5'd1;
      end
      FINISH: begin
        result_d = is_rem_q ? r_fix : q_fix;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
